// File: rtl/irqc_prio_if.sv
`timescale 1ns/1ps
// Wishbone slave bus of the priority interrupt controller: single-beat cycles,
// 32-bit data, 3-bit word address.
interface irqc_prio_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [2:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, input ack_o, dat_o);
    modport slave  (input cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, output ack_o, dat_o);
endinterface

// File: rtl/irqc_prio.sv
`timescale 1ns/1ps
// Prioritised interrupt controller: per-source priority, level/edge capture,
// optional input synchroniser and a non-preemptive request/acknowledge handshake.
module irqc_prio #(
    parameter int unsigned IW       = 4,
    parameter logic [7:0]  VEC_BASE = 8'h40,
    parameter int          SYNC     = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    irqc_prio_if.slave    wb,
    input  logic [IW-1:0] irq_in,
    output logic          irq_req,
    output logic [7:0]    irq_vec,
    output logic [2:0]    irq_lvl,
    input  logic          irq_ack
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] s, prev, pending, enable, edge_mode;
    logic [IW-1:0] elig, w1c, ack_clr, clr, lane_mask, wdata;
    logic [2:0]    prio [IW];
    logic [3:0]    cur_idx, idx_nx, win_idx;
    logic [2:0]    win_lvl, lvl_nx;
    logic [7:0]    vec_nx;
    logic          req_nx, win_any, cur_elig, cur_edge;
    logic          fire, wr;
    logic [31:0]   rd_data, prio_rd0, prio_rd1;

    if (SYNC != 0) begin : g_sync
        logic [IW-1:0] sync1, sync2;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync1 <= '0;
                sync2 <= '0;
            end else begin
                sync1 <= irq_in;
                sync2 <= sync1;
            end
        end
        assign s = sync2;
    end else begin : g_nosync
        assign s = irq_in;
    end

    assign fire = wb.cyc_i & wb.stb_i & ~wb.ack_o;
    assign wr   = fire & wb.we_i;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < IW; i++) lane_mask[i] = wb.sel_i[i/8];
    end

    assign wdata   = wb.dat_i[IW-1:0] & lane_mask;
    assign w1c     = (wr && wb.adr_i == 3'd0) ? wdata : '0;
    assign clr     = w1c | ack_clr;

    always_comb begin
        elig = '0;
        for (int i = 0; i < IW; i++) elig[i] = pending[i] & enable[i] & (prio[i] != 3'd0);
    end

    // Strictly-greater compare keeps the lowest index on a priority tie.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_lvl = '0;
        for (int i = 0; i < IW; i++) begin
            if (elig[i] && prio[i] > win_lvl) begin
                win_any = 1'b1;
                win_idx = 4'(i);
                win_lvl = prio[i];
            end
        end
    end

    always_comb begin
        cur_elig = 1'b0;
        cur_edge = 1'b0;
        for (int i = 0; i < IW; i++) begin
            if (cur_idx == 4'(i)) begin
                cur_elig = elig[i];
                cur_edge = edge_mode[i];
            end
        end
    end

    always_comb begin
        prio_rd0 = '0;
        prio_rd1 = '0;
        for (int i = 0; i < IW; i++) begin
            if (i < 8) prio_rd0[4*(i%8) +: 3] = prio[i];
            else       prio_rd1[4*(i%8) +: 3] = prio[i];
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb.adr_i)
            3'd0:    rd_data[IW-1:0] = pending;
            3'd1:    rd_data[IW-1:0] = enable;
            3'd2:    rd_data[IW-1:0] = edge_mode;
            3'd4:    rd_data = prio_rd0;
            3'd5:    rd_data = prio_rd1;
            3'd6:    rd_data = {irq_req, 12'b0, irq_lvl, 8'b0, irq_vec};
            default: rd_data = '0;
        endcase
    end

    // NOTE: every output of this process gets a default first, so no path leaves one unassigned.
    always_comb begin
        state_nx = state;
        req_nx   = irq_req;
        vec_nx   = irq_vec;
        lvl_nx   = irq_lvl;
        idx_nx   = cur_idx;
        ack_clr  = '0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nx = REQ;
                    req_nx   = 1'b1;
                    vec_nx   = VEC_BASE + {4'b0, win_idx};
                    lvl_nx   = win_lvl;
                    idx_nx   = win_idx;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nx = GAP;
                    req_nx   = 1'b0;
                    if (cur_edge) ack_clr = IW'(1) << cur_idx;
                end else if (!cur_elig) begin
                    state_nx = GAP;
                    req_nx   = 1'b0;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_vec <= '0;
            irq_lvl <= '0;
            cur_idx <= '0;
        end else begin
            state   <= state_nx;
            irq_req <= req_nx;
            irq_vec <= vec_nx;
            irq_lvl <= lvl_nx;
            cur_idx <= idx_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb.ack_o  <= 1'b0;
            wb.dat_o  <= '0;
            prev      <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_mode <= '0;
            for (int i = 0; i < IW; i++) prio[i] <= '0;
        end else begin
            wb.ack_o <= fire;
            if (fire) wb.dat_o <= rd_data;
            prev <= s;
            // NOTE: a fresh rising edge outranks a same-cycle clear, so no edge is ever lost.
            for (int i = 0; i < IW; i++) begin
                if (edge_mode[i]) pending[i] <= (pending[i] & ~clr[i]) | (s[i] & ~prev[i]);
                else              pending[i] <= s[i];
            end
            if (wr) begin
                if (wb.adr_i == 3'd1) enable    <= (enable & ~lane_mask) | wdata;
                if (wb.adr_i == 3'd2) edge_mode <= (edge_mode & ~lane_mask) | wdata;
                for (int i = 0; i < IW; i++) begin
                    if (wb.adr_i == ((i < 8) ? 3'd4 : 3'd5) && wb.sel_i[(i%8)/2])
                        prio[i] <= wb.dat_i[4*(i%8) +: 3];
                end
            end
        end
    end

endmodule

// File: tb/tb_irqc_prio.sv
`timescale 1ns/1ps
// Self-checking bench for irqc_prio: a register-level model is compared with the
// DUT every cycle, and directed scenarios pin the model with literal expectations.
module tb_irqc_prio;
    localparam int IW = 4;
    localparam int PH_IDLE = 0, PH_PRESENT = 1, PH_GAP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] irq_in;
    logic          irq_req;
    logic [7:0]    irq_vec;
    logic [2:0]    irq_lvl;
    logic          irq_ack;
    logic [31:0]   rd;

    int n_checks = 0;
    int n_fail   = 0;

    irqc_prio_if wb();

    irqc_prio #(.IW(IW), .VEC_BASE(8'h40), .SYNC(1)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb      (wb),
        .irq_in  (irq_in),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_lvl (irq_lvl),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [IW-1:0] m_sync1, m_sync2, m_prev, m_pend, m_en, m_edge;
    int          m_prio [IW];
    int          m_phase, m_cur, m_vec, m_lvl;
    bit          m_req, m_ack, m_rd, model_live;
    bit [31:0]   m_dat;

    function automatic bit elig(int i);
        return m_pend[i] && m_en[i] && (m_prio[i] != 0);
    endfunction

    function automatic bit [31:0] prio_word(int w);
        bit [31:0] r = '0;
        for (int i = 0; i < 8; i++)
            if (w*8 + i < IW) r[4*i +: 3] = 3'(m_prio[w*8 + i]);
        return r;
    endfunction

    function automatic bit [31:0] reg_read(int a);
        bit [31:0] r = '0;
        bit [2:0]  l = 3'(m_lvl);
        bit [7:0]  v = 8'(m_vec);
        case (a)
            0: r[IW-1:0] = m_pend;
            1: r[IW-1:0] = m_en;
            2: r[IW-1:0] = m_edge;
            4: r = prio_word(0);
            5: r = prio_word(1);
            6: r = {m_req, 12'b0, l, 8'b0, v};
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit [31:0]   bm, wd, word;
        bit [IW-1:0] sv, clr, npend;
        bit          fire;
        int          best, win, a;
        if (rst) begin
            m_sync1 = '0; m_sync2 = '0; m_prev = '0; m_pend = '0; m_en = '0; m_edge = '0;
            for (int i = 0; i < IW; i++) m_prio[i] = 0;
            m_phase = PH_IDLE; m_cur = 0; m_vec = 0; m_lvl = 0;
            m_req = 0; m_ack = 0; m_rd = 0; m_dat = '0;
            model_live = 1;
        end else begin
            sv   = m_sync2;
            fire = wb.cyc_i && wb.stb_i && !m_ack;
            a    = int'(wb.adr_i);
            bm   = {{8{wb.sel_i[3]}}, {8{wb.sel_i[2]}}, {8{wb.sel_i[1]}}, {8{wb.sel_i[0]}}};
            wd   = wb.dat_i & bm;
            clr  = '0;
            // highest priority first, then the lowest source holding it
            best = 0;
            for (int i = 0; i < IW; i++) if (elig(i) && m_prio[i] > best) best = m_prio[i];
            win = -1;
            for (int i = 0; i < IW; i++) if (win < 0 && best > 0 && elig(i) && m_prio[i] == best) win = i;
            if (fire) begin
                m_dat = reg_read(a);
                m_rd  = !wb.we_i;
            end
            case (m_phase)
                PH_IDLE: if (win >= 0) begin
                    m_phase = PH_PRESENT; m_req = 1; m_cur = win;
                    m_vec = (8'h40 + win) % 256; m_lvl = best;
                end
                PH_PRESENT: if (irq_ack) begin
                    if (m_edge[m_cur]) clr[m_cur] = 1'b1;
                    m_phase = PH_GAP; m_req = 0;
                end else if (!elig(m_cur)) begin
                    m_phase = PH_GAP; m_req = 0;
                end
                default: m_phase = PH_IDLE;
            endcase
            if (fire && wb.we_i && a == 0) clr = clr | wd[IW-1:0];
            for (int i = 0; i < IW; i++)
                npend[i] = m_edge[i] ? ((m_pend[i] && !clr[i]) || (sv[i] && !m_prev[i])) : sv[i];
            m_pend = npend;
            if (fire && wb.we_i) begin
                if (a == 1) m_en   = (m_en   & ~bm[IW-1:0]) | wd[IW-1:0];
                if (a == 2) m_edge = (m_edge & ~bm[IW-1:0]) | wd[IW-1:0];
                if (a == 4 || a == 5) begin
                    word = (prio_word(a - 4) & ~bm) | wd;
                    for (int i = 0; i < 8; i++)
                        if ((a-4)*8 + i < IW) m_prio[(a-4)*8 + i] = int'(word[4*i +: 3]);
                end
            end
            m_ack   = fire;
            m_prev  = sv;
            m_sync2 = m_sync1;
            m_sync1 = irq_in;
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (model_live) begin
            check("irq_req vs model", {31'b0, irq_req}, {31'b0, m_req});
            check("irq_vec vs model", {24'b0, irq_vec}, 32'(m_vec));
            check("irq_lvl vs model", {29'b0, irq_lvl}, 32'(m_lvl));
            check("ack_o vs model", {31'b0, wb.ack_o}, {31'b0, m_ack});
            if (m_ack && m_rd) check("dat_o vs model", wb.dat_o, m_dat);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_access(input bit we, input logic [2:0] a, input logic [31:0] d,
                             input logic [3:0] sel, output logic [31:0] data);
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we;
        wb.adr_i = a; wb.sel_i = sel; wb.dat_i = d;
        @(posedge clk); #1;
        check("ack_o one cycle after stb", {31'b0, wb.ack_o}, 32'd1);
        data = wb.dat_o;
        @(negedge clk);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_access(1'b1, a, d, 4'hF, unused_rd);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max_cycles);
        int k = 0;
        while (irq_req !== 1'b1 && k < max_cycles) begin
            @(posedge clk); #1;
            k++;
        end
        check("irq_req within cycle budget", {31'b0, irq_req}, 32'd1);
    endtask

    task automatic do_ack();
        @(negedge clk); irq_ack = 1'b1;
        @(posedge clk); #1;
        check("irq_req drops after ack", {31'b0, irq_req}, 32'd0);
        @(negedge clk); irq_ack = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1; irq_in = '0; irq_ack = 1'b0;
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        wb.adr_i = '0; wb.sel_i = '0; wb.dat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        check("irq_req after reset", {31'b0, irq_req}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            wb_access(1'b0, 3'(a), 32'h0, 4'hF, rd);
            check($sformatf("reset read adr %0d", a), rd, 32'h0);
        end

        // edge source 2 through the synchroniser: request on the fourth edge
        wr(3'd2, 32'h4);
        wr(3'd1, 32'h4);
        wr(3'd4, 32'h0000_0300);
        @(negedge clk); irq_in[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("irq_req at N+%0d", k), {31'b0, irq_req}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 1) begin
                @(negedge clk); irq_in[2] = 1'b0;
            end
        end
        check("edge src2 vec", {24'b0, irq_vec}, 32'h42);
        check("edge src2 lvl", {29'b0, irq_lvl}, 32'd3);
        do_ack();
        wb_access(1'b0, 3'd0, 32'h0, 4'hF, rd);
        check("pending cleared by ack", rd, 32'h0);
        wb_access(1'b0, 3'd6, 32'h0, 4'hF, rd);
        check("current after ack", rd, 32'h0003_0042);

        // level sources 0 and 3 tie at priority 5
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h9);
        wr(3'd4, 32'h0000_5005);
        @(negedge clk); irq_in[0] = 1'b1; irq_in[3] = 1'b1;
        wait_req(10);
        check("tie goes to src0", {24'b0, irq_vec}, 32'h40);
        check("tie lvl", {29'b0, irq_lvl}, 32'd5);
        do_ack();
        wait_req(10);
        check("level src0 re-presented", {24'b0, irq_vec}, 32'h40);
        @(negedge clk); irq_in[0] = 1'b0;
        tick(10);
        check("src3 after src0 drops req", {31'b0, irq_req}, 32'd1);
        check("src3 after src0 drops vec", {24'b0, irq_vec}, 32'h43);
        @(negedge clk); irq_in[3] = 1'b0;
        tick(10);
        check("no request with lines low", {31'b0, irq_req}, 32'd0);

        // no preemption by a later higher-priority source
        wr(3'd1, 32'hA);
        wr(3'd4, 32'h0000_6020);
        @(negedge clk); irq_in[1] = 1'b1;
        wait_req(10);
        check("src1 vec", {24'b0, irq_vec}, 32'h41);
        check("src1 lvl", {29'b0, irq_lvl}, 32'd2);
        @(negedge clk); irq_in[3] = 1'b1;
        tick(8);
        check("frozen vec under higher arrival", {24'b0, irq_vec}, 32'h41);
        check("frozen lvl under higher arrival", {29'b0, irq_lvl}, 32'd2);
        @(negedge clk); irq_ack = 1'b1; irq_in[1] = 1'b0;
        @(posedge clk); #1;
        check("irq_req drops after ack src1", {31'b0, irq_req}, 32'd0);
        @(negedge clk); irq_ack = 1'b0;
        wait_req(10);
        check("src3 after ack vec", {24'b0, irq_vec}, 32'h43);
        check("src3 after ack lvl", {29'b0, irq_lvl}, 32'd6);

        // level withdrawn before ack
        @(negedge clk); irq_in[3] = 1'b0;
        tick(10);
        check("withdrawn request stays low", {31'b0, irq_req}, 32'd0);
        wb_access(1'b0, 3'd6, 32'h0, 4'hF, rd);
        check("current after withdraw", rd, 32'h0006_0043);

        // byte-lane write of PRIO0
        wb_access(1'b1, 3'd4, 32'h7777_7777, 4'b0001, rd);
        wb_access(1'b0, 3'd4, 32'h0, 4'hF, rd);
        check("prio0 lane0 write", rd, 32'h0000_6077);

        // edge on src0 colliding with its W1C: the set survives
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h1);
        @(negedge clk); irq_in[0] = 1'b1;
        @(negedge clk); irq_in[0] = 1'b0;
        tick(6);
        wb_access(1'b0, 3'd0, 32'h0, 4'hF, rd);
        check("edge src0 latched", rd, 32'h1);
        @(negedge clk); irq_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(3'd0, 32'h1);
        @(negedge clk); irq_in[0] = 1'b0;
        wb_access(1'b0, 3'd0, 32'h0, 4'hF, rd);
        check("set wins over W1C", rd, 32'h1);
        wr(3'd0, 32'h1);
        wb_access(1'b0, 3'd0, 32'h0, 4'hF, rd);
        check("W1C clears edge pending", rd, 32'h0);

        // reset in the middle of a request
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h1);
        @(negedge clk); irq_in[0] = 1'b1;
        wait_req(10);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("reset drops irq_req", {31'b0, irq_req}, 32'd0);
        check("reset clears irq_vec", {24'b0, irq_vec}, 32'h0);
        @(negedge clk); rst = 1'b0; irq_in = '0;
        tick(8);
        check("idle after reset", {31'b0, irq_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
